// File: rtl/uart_cmd_ctrl.sv
// Byte-stream command decoder: frames of HDR, op, hi, lo, chk arrive from a UART
// receiver and are presented as one command held until the consumer acks.
module uart_cmd_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd52080,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_byte,
  output logic        clr_rdy,
  output logic        cmd_vld,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_data,
  input  logic        cmd_ack,
  output logic        chk_err,
  output logic        tmo_err,
  output logic        busy,
  output logic [7:0]  frm_cnt
);

  typedef enum logic [2:0] {
    WAIT_HDR, GET_OP, GET_HI, GET_LO, GET_CHK, HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  op_r, hi_r, lo_r;
  logic [15:0] tmo_cnt;
  logic        accept, in_frame, tmo_hit, chk_ok;
  logic [7:0]  sum;

  assign busy = (state != WAIT_HDR);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    // clr_rdy high means the byte on rx_byte was just consumed; the receiver
    // has not dropped rx_rdy yet, so skip that cycle.
    accept    = rx_rdy && (state != HOLD) && !clr_rdy;
    in_frame  = (state == GET_OP) || (state == GET_HI) ||
                (state == GET_LO) || (state == GET_CHK);
    tmo_hit   = in_frame && !accept && (tmo_cnt == TIMEOUT - 16'd1);
    sum       = op_r + hi_r + lo_r;
    chk_ok    = (rx_byte == sum);

    unique case (state)
      WAIT_HDR: if (accept && rx_byte == HDR) state_nxt = GET_OP;
      GET_OP:   if (accept) state_nxt = GET_HI;
      GET_HI:   if (accept) state_nxt = GET_LO;
      GET_LO:   if (accept) state_nxt = GET_CHK;
      GET_CHK:  if (accept) state_nxt = chk_ok ? HOLD : WAIT_HDR;
      HOLD:     if (cmd_vld && cmd_ack) state_nxt = WAIT_HDR;
      default:  state_nxt = WAIT_HDR;
    endcase

    if (tmo_hit) state_nxt = WAIT_HDR;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= WAIT_HDR;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rdy  <= 1'b0;
      chk_err  <= 1'b0;
      tmo_err  <= 1'b0;
      cmd_vld  <= 1'b0;
      cmd_op   <= 8'h00;
      cmd_data <= 16'h0000;
      frm_cnt  <= 8'h00;
      op_r     <= 8'h00;
      hi_r     <= 8'h00;
      lo_r     <= 8'h00;
      tmo_cnt  <= 16'h0000;
    end else begin
      clr_rdy <= accept;
      chk_err <= accept && (state == GET_CHK) && !chk_ok;
      tmo_err <= tmo_hit;

      if (accept) begin
        case (state)
          GET_OP:  op_r <= rx_byte;
          GET_HI:  hi_r <= rx_byte;
          GET_LO:  lo_r <= rx_byte;
          default: ;
        endcase
      end

      if (accept && (state == GET_CHK) && chk_ok) begin
        cmd_vld  <= 1'b1;
        cmd_op   <= op_r;
        cmd_data <= {hi_r, lo_r};
        frm_cnt  <= frm_cnt + 8'd1;
      end else if (cmd_vld && cmd_ack) begin
        cmd_vld  <= 1'b0;
      end

      // Counter restarts with each byte so the limit is per gap, not per frame.
      if (accept || state_nxt == WAIT_HDR) tmo_cnt <= 16'h0000;
      else if (in_frame)                   tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a handshaking receiver model feeds frames
// and every observation is checked against hand-computed values.
module tb_uart_cmd_ctrl;

  localparam logic [15:0] TMO = 16'd40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        clr_rdy;
  logic        cmd_vld;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_ack = 1'b0;
  logic        chk_err;
  logic        tmo_err;
  logic        busy;
  logic [7:0]  frm_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int clr_pulses = 0;
  int chk_pulses = 0;
  int tmo_pulses = 0;

  uart_cmd_ctrl #(.TIMEOUT(TMO), .HDR(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_byte(rx_byte),
    .clr_rdy(clr_rdy), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ack(cmd_ack), .chk_err(chk_err), .tmo_err(tmo_err), .busy(busy),
    .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_rdy) clr_pulses++;
    if (chk_err) chk_pulses++;
    if (tmo_err) tmo_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and wait (bounded) for the controller to consume it.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_byte = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (clr_rdy) got = 1'b1;
    end
    if (got) rx_rdy = 1'b0;
    else check("clr_rdy_wait", {31'd0, got}, 32'd1);
  endtask

  task automatic ack_cmd();
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
  endtask

  initial begin
    int clr_base;

    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_frm_cnt", {24'd0, frm_cnt}, 32'd0);
    check("rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame: 12+34+56 = 9C
    clr_base = clr_pulses;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check("f1_busy_mid", {31'd0, busy}, 32'd1);
    check("f1_vld_early", {31'd0, cmd_vld}, 32'd0);
    send_byte(8'h9C);
    check("f1_vld",  {31'd0, cmd_vld}, 32'd1);
    check("f1_op",   {24'd0, cmd_op}, 32'h12);
    check("f1_data", {16'd0, cmd_data}, 32'h3456);
    check("f1_cnt",  {24'd0, frm_cnt}, 32'd1);
    #1 check("f1_clr_pulses", clr_pulses - clr_base, 32'd5);
    repeat (4) @(negedge clk);
    check("f1_hold_vld", {31'd0, cmd_vld}, 32'd1);
    check("f1_hold_op",  {24'd0, cmd_op}, 32'h12);
    ack_cmd();
    check("f1_ack_vld",  {31'd0, cmd_vld}, 32'd0);
    check("f1_ack_busy", {31'd0, busy}, 32'd0);
    ack_cmd();
    check("ack_idle_vld", {31'd0, cmd_vld}, 32'd0);

    // Bad checksum
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'h9D);
    check("f2_chk_err", {31'd0, chk_err}, 32'd1);
    check("f2_vld",     {31'd0, cmd_vld}, 32'd0);
    check("f2_cnt",     {24'd0, frm_cnt}, 32'd1);
    @(negedge clk);
    check("f2_chk_err_pulse", {31'd0, chk_err}, 32'd0);
    check("f2_busy", {31'd0, busy}, 32'd0);
    check("f2_chk_pulses", chk_pulses, 32'd1);

    // Junk before header: 01+02+03 = 06
    send_byte(8'h00); send_byte(8'hFF);
    check("f3_junk_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h06);
    check("f3_vld",  {31'd0, cmd_vld}, 32'd1);
    check("f3_op",   {24'd0, cmd_op}, 32'h01);
    check("f3_data", {16'd0, cmd_data}, 32'h0203);
    check("f3_cnt",  {24'd0, frm_cnt}, 32'd2);
    ack_cmd();

    // Timeout after partial frame: fires exactly TMO cycles after last byte
    send_byte(8'hA5); send_byte(8'h77);
    repeat (int'(TMO) - 1) @(negedge clk);
    check("tmo_not_yet", {31'd0, tmo_err}, 32'd0);
    check("tmo_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("tmo_err", {31'd0, tmo_err}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_op_kept", {24'd0, cmd_op}, 32'h01);
    @(negedge clk);
    check("tmo_pulse", {31'd0, tmo_err}, 32'd0);
    check("tmo_pulses", tmo_pulses, 32'd1);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h60);
    check("f4_vld",  {31'd0, cmd_vld}, 32'd1);
    check("f4_op",   {24'd0, cmd_op}, 32'h10);
    check("f4_data", {16'd0, cmd_data}, 32'h2030);
    check("f4_cnt",  {24'd0, frm_cnt}, 32'd3);
    ack_cmd();

    // Back-pressure in HOLD: AA+BB+CC = 0x231 -> 31
    send_byte(8'hA5); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'h31);
    check("f5_vld", {31'd0, cmd_vld}, 32'd1);
    check("f5_cnt", {24'd0, frm_cnt}, 32'd4);
    @(negedge clk);
    clr_base = clr_pulses;
    rx_byte = 8'hA5;
    rx_rdy  = 1'b1;
    repeat (6) @(negedge clk);
    #1 check("hold_no_clr", clr_pulses - clr_base, 32'd0);
    check("hold_op",  {24'd0, cmd_op}, 32'hAA);
    check("hold_data", {16'd0, cmd_data}, 32'hBBCC);
    ack_cmd();
    check("hold_ack_vld", {31'd0, cmd_vld}, 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h06);
    check("f6_vld",  {31'd0, cmd_vld}, 32'd1);
    check("f6_op",   {24'd0, cmd_op}, 32'h01);
    check("f6_data", {16'd0, cmd_data}, 32'h0203);
    check("f6_cnt",  {24'd0, frm_cnt}, 32'd5);

    // Reset mid-frame (from HOLD ack into a partial frame)
    ack_cmd();
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_vld",  {31'd0, cmd_vld}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_cnt",  {24'd0, frm_cnt}, 32'd0);
    check("mrst_op",   {24'd0, cmd_op}, 32'h00);
    check("mrst_data", {16'd0, cmd_data}, 32'h0000);
    check("mrst_clr",  {31'd0, clr_rdy}, 32'd0);
    repeat (int'(TMO) + 10) @(negedge clk);
    #1;
    check("mrst_no_tmo", tmo_pulses, 32'd1);
    check("mrst_no_chk", chk_pulses, 32'd1);
    check("mrst_busy_late", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
